// File: rtl/motor_drive_controller.sv
// Two-wheel drive controller: decodes the 4-bit steering command, ramps each wheel's duty,
// and drives PWM into the H-bridge pairs with a coast interval around every rotation reversal.
module motor_drive_controller #(
  parameter int CNT_W      = 10,
  parameter int PWM_PERIOD = 1000,
  parameter int DUTY_FULL  = 900,
  parameter int DUTY_VEER  = 600,
  parameter int DUTY_HARD  = 300,
  parameter int RAMP_STEP  = 50,
  parameter int DEADTIME   = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       DIR,
  input  logic             Direction,
  output logic             left_in_a,
  output logic             left_in_b,
  output logic             right_in_a,
  output logic             right_in_b,
  output logic [CNT_W-1:0] left_duty,
  output logic [CNT_W-1:0] right_duty,
  output logic             moving
);

  typedef enum logic [1:0] {RUN, RAMP_DOWN, DEAD} wheel_state_t;

  localparam int DW = $clog2(DEADTIME + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PWM_PERIOD - 1);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(RAMP_STEP);
  localparam logic [CNT_W-1:0] FULL = CNT_W'((DUTY_FULL > PWM_PERIOD) ? PWM_PERIOD : DUTY_FULL);
  localparam logic [CNT_W-1:0] VEER = CNT_W'((DUTY_VEER > PWM_PERIOD) ? PWM_PERIOD : DUTY_VEER);
  localparam logic [CNT_W-1:0] HARD = CNT_W'((DUTY_HARD > PWM_PERIOD) ? PWM_PERIOD : DUTY_HARD);
  localparam logic [DW-1:0]    DEAD_LAST = DW'(DEADTIME - 1);

  logic [CNT_W-1:0] cnt;
  logic [3:0]       dir_q;
  logic             dirn_q;
  logic             wrap;
  logic             stop_now;
  logic [CNT_W-1:0] dec_duty [2];
  logic [1:0]       dec_rot;
  logic [1:0]       tgt_rot;
  logic [1:0]       req_rot;
  logic [1:0]       rot;
  logic [1:0]       pwm;
  logic [1:0]       br_a;
  logic [1:0]       br_b;
  wheel_state_t     state [2];
  logic [CNT_W-1:0] duty [2];
  logic [DW-1:0]    dcnt [2];

  function automatic logic [CNT_W-1:0] ramp(input logic [CNT_W-1:0] cur,
                                            input logic [CNT_W-1:0] tgt);
    logic [CNT_W-1:0] r;
    r = tgt;
    if (tgt > cur) begin
      if (tgt - cur > STEP) r = cur + STEP;
    end else if (cur - tgt > STEP) begin
      r = cur - STEP;
    end
    return r;
  endfunction

  assign wrap = (cnt == LAST);
  // Between wraps a wheel acts on the rotation latched at the last wrap; at a wrap it sees the fresh decode.
  assign req_rot = wrap ? dec_rot : tgt_rot;
  assign pwm = {(cnt < duty[1]), (cnt < duty[0])};

  always_comb begin
    dec_duty[0] = '0;
    dec_duty[1] = '0;
    dec_rot     = {dirn_q, dirn_q};
    stop_now    = 1'b0;
    case (dir_q)
      4'b0000: begin dec_duty[0] = FULL; dec_duty[1] = FULL; end
      4'b1001: begin dec_duty[0] = FULL; dec_duty[1] = VEER; end
      4'b1010: begin dec_duty[0] = FULL; dec_duty[1] = HARD; end
      4'b1011: begin dec_duty[0] = FULL; dec_duty[1] = FULL; dec_rot[1] = ~dirn_q; end
      4'b0101: begin dec_duty[0] = VEER; dec_duty[1] = FULL; end
      4'b0110: begin dec_duty[0] = HARD; dec_duty[1] = FULL; end
      4'b0111: begin dec_duty[0] = FULL; dec_duty[1] = FULL; dec_rot[0] = ~dirn_q; end
      default: stop_now = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      dir_q   <= 4'b1111;
      dirn_q  <= 1'b1;
      moving  <= 1'b0;
      tgt_rot <= 2'b11;
      rot     <= 2'b11;
      br_a    <= 2'b00;
      br_b    <= 2'b00;
      for (int w = 0; w < 2; w++) begin
        state[w] <= RUN;
        duty[w]  <= '0;
        dcnt[w]  <= '0;
      end
    end else begin
      cnt    <= wrap ? '0 : cnt + 1'b1;
      dir_q  <= DIR;
      dirn_q <= Direction;
      moving <= (duty[0] != '0) || (duty[1] != '0);
      if (wrap) tgt_rot <= dec_rot;
      for (int w = 0; w < 2; w++) begin
        case (state[w])
          RUN: begin
            if (stop_now) begin
              duty[w] <= '0;
            end else if (req_rot[w] != rot[w]) begin
              if (duty[w] != '0) begin
                state[w] <= RAMP_DOWN;
                if (wrap) duty[w] <= ramp(duty[w], '0);
              end else begin
                state[w] <= DEAD;
                dcnt[w]  <= '0;
              end
            end else if (wrap) begin
              duty[w] <= ramp(duty[w], dec_duty[w]);
            end
          end
          RAMP_DOWN: begin
            if (req_rot[w] == rot[w] && !stop_now) begin
              state[w] <= RUN;
              if (wrap) duty[w] <= ramp(duty[w], dec_duty[w]);
            end else if (duty[w] == '0) begin
              state[w] <= DEAD;
              dcnt[w]  <= '0;
            end else if (stop_now) begin
              duty[w] <= '0;
            end else if (wrap) begin
              duty[w] <= ramp(duty[w], '0);
            end
          end
          DEAD: begin
            if (dcnt[w] == DEAD_LAST) begin
              rot[w]   <= req_rot[w];
              state[w] <= RUN;
            end else begin
              dcnt[w] <= dcnt[w] + 1'b1;
            end
          end
          default: state[w] <= RUN;
        endcase
        // Brake only with zero duty so both low-side and high-side are never driven under load.
        if (state[w] == DEAD) begin
          br_a[w] <= 1'b0;
          br_b[w] <= 1'b0;
        end else if (state[w] == RUN && stop_now && duty[w] == '0) begin
          br_a[w] <= 1'b1;
          br_b[w] <= 1'b1;
        end else begin
          br_a[w] <= rot[w] & pwm[w];
          br_b[w] <= ~rot[w] & pwm[w];
        end
      end
    end
  end

  assign left_in_a  = br_a[0];
  assign left_in_b  = br_b[0];
  assign right_in_a = br_a[1];
  assign right_in_b = br_b[1];
  assign left_duty  = duty[0];
  assign right_duty = duty[1];

endmodule
